byte_fetch_ctrl: RTL and testbench

BYTE_FETCH_CTRL -- requirements
Module: byte_fetch_ctrl

---
 rtl/vvc_dec_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 61 ++++++
 rtl/byte_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_byte_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvc_dec_pkg.sv
// Shared decoder types and constants.
// Used by the byte fetch controller and its FIFO.
package vvc_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT0,
    ST_INIT1,
    ST_RUN,
    ST_WAIT
  } fetch_state_t;

  localparam int BYTE_BITS = 8;
  localparam logic signed [3:0] BITS_INIT = 4'sb1000;

  function automatic logic nb_ok(input logic [2:0] n);
    return (n != 3'd0) && (n <= 3'd4);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Prefetch byte FIFO with valid/ready push and flush.
// A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign o_ready = (!w_full || w_pop) && !rst;
  assign w_push  = i_valid && o_ready;
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/byte_fetch_ctrl.sv
// Byte fetch controller: feeds readByte from a prefetch FIFO,
// tracking bitsNeeded and stalling the core when the FIFO runs dry.
module byte_fetch_ctrl
  import vvc_dec_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        bs_byte,
  input  logic              bs_valid,
  output logic              bs_ready,
  input  logic              consume,
  input  logic [2:0]        num_bits,
  input  logic              is_ep,
  output logic [7:0]        bitstream,
  output logic              flag,
  output logic signed [3:0] bitsNeeded,
  output logic signed [3:0] bitsNeeded_sel,
  output logic              init_load,
  output logic              init_idx,
  output logic              stall,
  output logic              ready
);

  fetch_state_t r_state;

  logic [7:0]        r_bs;
  logic              r_flag;
  logic signed [3:0] r_bn;
  logic signed [3:0] r_sel;
  logic [3:0]        r_pend;
  logic              r_init_load;
  logic              r_init_idx;
  logic              r_stall;
  logic              r_ready;

  logic              w_empty;
  logic [7:0]        w_head;
  logic              w_fifo_ready;
  logic              w_flush;
  logic              w_pop;
  logic              w_cons;
  logic signed [4:0] w_sum;
  logic [3:0]        w_refill;
  logic [3:0]        w_pend_refill;
  logic signed [3:0] w_sel;

  assign w_flush = start && (r_state != ST_IDLE);
  assign w_cons  = consume && nb_ok(num_bits);
  assign w_sum   = $signed({r_bn[3], r_bn}) + $signed({2'b00, num_bits});

  // Sum is 0..3 whenever a refill happens, so 4-bit wrap is exact.
  assign w_refill      = w_sum[3:0] - 4'(BYTE_BITS);
  assign w_pend_refill = r_pend - 4'(BYTE_BITS);
  assign w_sel         = is_ep ? -$signed({1'b0, num_bits}) : 4'sd0;

  always_comb begin
    w_pop = 1'b0;
    if (!start) begin
      case (r_state)
        ST_INIT0, ST_INIT1: w_pop = !w_empty;
        ST_RUN:  w_pop = w_cons && !w_sum[4] && !w_empty;
        ST_WAIT: w_pop = !w_empty;
        default: w_pop = 1'b0;
      endcase
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_valid (bs_valid),
    .i_data  (bs_byte),
    .o_ready (w_fifo_ready),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bs        <= '0;
      r_flag      <= 1'b0;
      r_bn        <= BITS_INIT;
      r_sel       <= '0;
      r_pend      <= '0;
      r_init_load <= 1'b0;
      r_init_idx  <= 1'b0;
      r_stall     <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_flag      <= 1'b0;
      r_init_load <= 1'b0;
      if (start) begin
        r_state <= ST_INIT0;
        r_stall <= 1'b0;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_INIT0: begin
            if (!w_empty) begin
              r_bs        <= w_head;
              r_init_load <= 1'b1;
              r_init_idx  <= 1'b0;
              r_stall     <= 1'b0;
              r_state     <= ST_INIT1;
            end else begin
              r_stall <= 1'b1;
            end
          end
          ST_INIT1: begin
            if (!w_empty) begin
              r_bs        <= w_head;
              r_init_load <= 1'b1;
              r_init_idx  <= 1'b1;
              r_stall     <= 1'b0;
              r_bn        <= BITS_INIT;
              r_ready     <= 1'b1;
              r_state     <= ST_RUN;
            end else begin
              r_stall <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_cons) begin
              if (w_sum[4]) begin
                r_bn <= w_sum[3:0];
              end else if (!w_empty) begin
                r_bs   <= w_head;
                r_flag <= 1'b1;
                r_bn   <= w_refill;
                r_sel  <= w_sel;
              end else begin
                r_pend  <= w_sum[3:0];
                r_sel   <= w_sel;
                r_stall <= 1'b1;
                r_state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (!w_empty) begin
              r_bs    <= w_head;
              r_flag  <= 1'b1;
              r_bn    <= w_pend_refill;
              r_stall <= 1'b0;
              r_state <= ST_RUN;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bs_ready       = w_fifo_ready;
  assign bitstream      = r_bs;
  assign flag           = r_flag;
  assign bitsNeeded     = r_bn;
  assign bitsNeeded_sel = r_sel;
  assign init_load      = r_init_load;
  assign init_idx       = r_init_idx;
  assign stall          = r_stall;
  assign ready          = r_ready;

endmodule

// File: tb/tb_byte_fetch_ctrl.sv
// Directed bench for byte_fetch_ctrl.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_byte_fetch_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        bs_byte;
  logic              bs_valid;
  logic              bs_ready;
  logic              consume;
  logic [2:0]        num_bits;
  logic              is_ep;
  logic [7:0]        bitstream;
  logic              flag;
  logic signed [3:0] bitsNeeded;
  logic signed [3:0] bitsNeeded_sel;
  logic              init_load;
  logic              init_idx;
  logic              stall;
  logic              ready;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic signed [3:0] M8 = 4'(-8);
  localparam logic signed [3:0] M7 = 4'(-7);
  localparam logic signed [3:0] M5 = 4'(-5);
  localparam logic signed [3:0] M4 = 4'(-4);
  localparam logic signed [3:0] M2 = 4'(-2);
  localparam logic signed [3:0] M1 = 4'(-1);
  localparam logic signed [3:0] Z0 = 4'sd0;

  byte_fetch_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bs_byte        (bs_byte),
    .bs_valid       (bs_valid),
    .bs_ready       (bs_ready),
    .consume        (consume),
    .num_bits       (num_bits),
    .is_ep          (is_ep),
    .bitstream      (bitstream),
    .flag           (flag),
    .bitsNeeded     (bitsNeeded),
    .bitsNeeded_sel (bitsNeeded_sel),
    .init_load      (init_load),
    .init_idx       (init_idx),
    .stall          (stall),
    .ready          (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bs_byte  = b;
    bs_valid = 1'b1;
    tick();
    bs_valid = 1'b0;
  endtask

  task automatic cons(input logic [2:0] n, input logic e);
    consume  = 1'b1;
    num_bits = n;
    is_ep    = e;
    tick();
    consume  = 1'b0;
    is_ep    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++; if (bitsNeeded !== M8) $display("FAIL rst_bn act=%0d exp=-8", bitsNeeded); else n_pass++;
    n_chk++; if (bitsNeeded_sel !== Z0) $display("FAIL rst_sel act=%0d exp=0", bitsNeeded_sel); else n_pass++;
    n_chk++; if (bitstream !== 8'h00) $display("FAIL rst_bs act=%h exp=00", bitstream); else n_pass++;
    n_chk++; if (flag !== 1'b0) $display("FAIL rst_flag act=%b exp=0", flag); else n_pass++;
    n_chk++; if (init_load !== 1'b0) $display("FAIL rst_init act=%b exp=0", init_load); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall act=%b exp=0", stall); else n_pass++;
    n_chk++; if (ready !== 1'b0) $display("FAIL rst_ready act=%b exp=0", ready); else n_pass++;
    n_chk++; if (bs_ready !== 1'b0) $display("FAIL rst_bsrdy act=%b exp=0", bs_ready); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_init();
    push(8'hA5);
    push(8'h3C);
    pulse_start();
    tick();
    n_chk++; if (init_load !== 1'b1 || init_idx !== 1'b0 || bitstream !== 8'hA5)
      $display("FAIL init0 act=%b/%b/%h exp=1/0/a5", init_load, init_idx, bitstream); else n_pass++;
    n_chk++; if (ready !== 1'b0) $display("FAIL init0_ready act=%b exp=0", ready); else n_pass++;
    tick();
    n_chk++; if (init_load !== 1'b1 || init_idx !== 1'b1 || bitstream !== 8'h3C)
      $display("FAIL init1 act=%b/%b/%h exp=1/1/3c", init_load, init_idx, bitstream); else n_pass++;
    n_chk++; if (ready !== 1'b1 || bitsNeeded !== M8)
      $display("FAIL init_done act=%b/%0d exp=1/-8", ready, bitsNeeded); else n_pass++;
    tick();
    n_chk++; if (init_load !== 1'b0) $display("FAIL init_strobe act=%b exp=0", init_load); else n_pass++;
  endtask

  task automatic test_regular();
    cons(3'd3, 1'b0);
    n_chk++; if (bitsNeeded !== M5 || flag !== 1'b0)
      $display("FAIL reg_acc1 act=%0d/%b exp=-5/0", bitsNeeded, flag); else n_pass++;
    cons(3'd3, 1'b0);
    n_chk++; if (bitsNeeded !== M2) $display("FAIL reg_acc2 act=%0d exp=-2", bitsNeeded); else n_pass++;
    push(8'h11);
    n_chk++; if (flag !== 1'b0) $display("FAIL reg_noflag act=%b exp=0", flag); else n_pass++;
    cons(3'd3, 1'b0);
    n_chk++; if (flag !== 1'b1 || bitstream !== 8'h11)
      $display("FAIL reg_flag act=%b/%h exp=1/11", flag, bitstream); else n_pass++;
    n_chk++; if (bitsNeeded !== M7 || bitsNeeded_sel !== Z0)
      $display("FAIL reg_bn act=%0d/%0d exp=-7/0", bitsNeeded, bitsNeeded_sel); else n_pass++;
    tick();
    n_chk++; if (flag !== 1'b0) $display("FAIL reg_pulse act=%b exp=0", flag); else n_pass++;
  endtask

  task automatic test_ep();
    cons(3'd4, 1'b0);
    cons(3'd2, 1'b0);
    n_chk++; if (bitsNeeded !== M1) $display("FAIL ep_pre act=%0d exp=-1", bitsNeeded); else n_pass++;
    push(8'h22);
    cons(3'd2, 1'b1);
    n_chk++; if (flag !== 1'b1 || bitstream !== 8'h22)
      $display("FAIL ep_flag act=%b/%h exp=1/22", flag, bitstream); else n_pass++;
    n_chk++; if (bitsNeeded !== M7 || bitsNeeded_sel !== M2)
      $display("FAIL ep_bn act=%0d/%0d exp=-7/-2", bitsNeeded, bitsNeeded_sel); else n_pass++;
  endtask

  task automatic test_bad_nbits();
    cons(3'd0, 1'b0);
    n_chk++; if (bitsNeeded !== M7) $display("FAIL nb0 act=%0d exp=-7", bitsNeeded); else n_pass++;
    cons(3'd5, 1'b0);
    n_chk++; if (bitsNeeded !== M7) $display("FAIL nb5 act=%0d exp=-7", bitsNeeded); else n_pass++;
    cons(3'd7, 1'b0);
    n_chk++; if (bitsNeeded !== M7 || flag !== 1'b0)
      $display("FAIL nb7 act=%0d/%b exp=-7/0", bitsNeeded, flag); else n_pass++;
  endtask

  task automatic test_starve();
    cons(3'd4, 1'b0);
    cons(3'd2, 1'b0);
    cons(3'd1, 1'b0);
    n_chk++; if (stall !== 1'b1 || flag !== 1'b0)
      $display("FAIL starve_stall act=%b/%b exp=1/0", stall, flag); else n_pass++;
    n_chk++; if (ready !== 1'b1) $display("FAIL starve_ready act=%b exp=1", ready); else n_pass++;
    cons(3'd4, 1'b0);
    n_chk++; if (stall !== 1'b1) $display("FAIL starve_hold act=%b exp=1", stall); else n_pass++;
    push(8'h77);
    n_chk++; if (stall !== 1'b1 || flag !== 1'b0)
      $display("FAIL starve_push act=%b/%b exp=1/0", stall, flag); else n_pass++;
    tick();
    n_chk++; if (flag !== 1'b1 || bitstream !== 8'h77)
      $display("FAIL starve_flag act=%b/%h exp=1/77", flag, bitstream); else n_pass++;
    n_chk++; if (bitsNeeded !== M8 || stall !== 1'b0)
      $display("FAIL starve_bn act=%0d/%b exp=-8/0", bitsNeeded, stall); else n_pass++;
  endtask

  task automatic test_full();
    logic [7:0] exp_b;
    for (int i = 1; i <= 4; i++) push(8'(i));
    n_chk++; if (bs_ready !== 1'b0) $display("FAIL full_rdy act=%b exp=0", bs_ready); else n_pass++;
    cons(3'd4, 1'b0);
    n_chk++; if (bitsNeeded !== M4) $display("FAIL full_acc act=%0d exp=-4", bitsNeeded); else n_pass++;
    bs_byte  = 8'h05;
    bs_valid = 1'b1;
    consume  = 1'b1;
    num_bits = 3'd4;
    #1;
    n_chk++; if (bs_ready !== 1'b1) $display("FAIL full_rdy_pop act=%b exp=1", bs_ready); else n_pass++;
    @(posedge clk);
    #1;
    bs_valid = 1'b0;
    consume  = 1'b0;
    n_chk++; if (flag !== 1'b1 || bitstream !== 8'h01)
      $display("FAIL full_pop act=%b/%h exp=1/01", flag, bitstream); else n_pass++;
    n_chk++; if (bs_ready !== 1'b0) $display("FAIL full_cnt act=%b exp=0", bs_ready); else n_pass++;
    for (int i = 2; i <= 5; i++) begin
      exp_b = 8'(i);
      cons(3'd4, 1'b0);
      cons(3'd4, 1'b0);
      n_chk++; if (flag !== 1'b1 || bitstream !== exp_b)
        $display("FAIL full_order act=%b/%h exp=1/%h", flag, bitstream, exp_b); else n_pass++;
    end
    n_chk++; if (bs_ready !== 1'b1) $display("FAIL full_drain act=%b exp=1", bs_ready); else n_pass++;
  endtask

  task automatic test_restart();
    push(8'h99);
    pulse_start();
    n_chk++; if (ready !== 1'b0) $display("FAIL rs_ready act=%b exp=0", ready); else n_pass++;
    tick();
    n_chk++; if (stall !== 1'b1 || init_load !== 1'b0)
      $display("FAIL rs_flush act=%b/%b exp=1/0", stall, init_load); else n_pass++;
    push(8'hB1);
    tick();
    n_chk++; if (init_load !== 1'b1 || init_idx !== 1'b0 || bitstream !== 8'hB1)
      $display("FAIL rs_init0 act=%b/%b/%h exp=1/0/b1", init_load, init_idx, bitstream); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL rs_unstall act=%b exp=0", stall); else n_pass++;
    push(8'hB2);
    tick();
    n_chk++; if (init_idx !== 1'b1 || bitstream !== 8'hB2 || ready !== 1'b1)
      $display("FAIL rs_init1 act=%b/%h/%b exp=1/b2/1", init_idx, bitstream, ready); else n_pass++;
  endtask

  task automatic test_reset_wait();
    cons(3'd4, 1'b0);
    cons(3'd4, 1'b0);
    n_chk++; if (stall !== 1'b1) $display("FAIL rw_wait act=%b exp=1", stall); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (stall !== 1'b0 || ready !== 1'b0 || flag !== 1'b0)
      $display("FAIL rw_async act=%b/%b/%b exp=0/0/0", stall, ready, flag); else n_pass++;
    n_chk++; if (bitsNeeded !== M8 || bitsNeeded_sel !== Z0 || bitstream !== 8'h00)
      $display("FAIL rw_vals act=%0d/%0d/%h exp=-8/0/00", bitsNeeded, bitsNeeded_sel, bitstream); else n_pass++;
    n_chk++; if (bs_ready !== 1'b0 || init_load !== 1'b0)
      $display("FAIL rw_rdy act=%b/%b exp=0/0", bs_ready, init_load); else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    push(8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (flag !== 1'b0 || ready !== 1'b0)
        $display("FAIL rw_noflag act=%b/%b exp=0/0", flag, ready); else n_pass++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    bs_byte  = 8'h00;
    bs_valid = 1'b0;
    consume  = 1'b0;
    num_bits = 3'd0;
    is_ep    = 1'b0;
    test_reset();
    test_init();
    test_regular();
    test_ep();
    test_bad_nbits();
    test_starve();
    test_full();
    test_restart();
    test_reset_wait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
